// File: rtl/mips_div_pkg.sv
// Shared types and sizing for the MIPS DIV/DIVU unit.
// Holds the FSM state encoding and the default operand width.
package mips_div_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } div_state_t;
endpackage

// File: rtl/mips_div_unit_sub_step.sv
// Combinational N-bit ripple subtractor chained from 1-bit sub cells.
// Returns a - b and the final borrow (set when b > a).
module div_sub_step #(
    parameter int N = 33
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);
    logic [N:0] bchain;

    assign bchain[0] = 1'b0;

    for (genvar i = 0; i < N; i++) begin : g_cell
        sub u_sub (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (bchain[i]),
            .d    (diff[i]),
            .bout (bchain[i+1])
        );
    end

    assign borrow = bchain[N];
endmodule

// File: rtl/sub.sv
// One-bit full subtractor cell: d = a - b - cin, with borrow out.
module sub (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ cin;
    assign bout = (~a & b) | (~(a ^ b) & cin);
endmodule

// File: rtl/mips_div_unit.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU producing LO (quotient)
// and HI (remainder), one quotient bit per clock on magnitudes, sign fixed at the end.
module mips_div_unit
    import mips_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div0
);
    localparam int CW = $clog2(WIDTH);

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgn_quo_q, sgn_quo_d;
    logic             sgn_rem_q, sgn_rem_d;
    logic             zero_q, zero_d;
    logic [WIDTH:0]   prem_q, prem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             div0_q, div0_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    // The working dividend doubles as the quotient shift register.
    assign shifted = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]};

    div_sub_step #(.N(WIDTH + 1)) u_sub_step (
        .a      (shifted),
        .b      ({1'b0, dvs_q}),
        .diff   (diff),
        .borrow (borrow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sgn_quo_q <= 1'b0;
            sgn_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sgn_quo_q <= sgn_quo_d;
            sgn_rem_q <= sgn_rem_d;
            zero_q    <= zero_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            div0_q    <= div0_d;
        end
    end

    always_ff @(posedge clk) begin
        prem_q <= prem_d;
        dvd_q  <= dvd_d;
        dvs_q  <= dvs_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        sgn_quo_d = sgn_quo_q;
        sgn_rem_d = sgn_rem_q;
        zero_d    = zero_q;
        prem_d    = prem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        div0_d    = div0_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sgn_quo_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    sgn_rem_d = is_signed & dividend[WIDTH-1];
                    dvd_d     = mag(dividend, is_signed);
                    dvs_d     = mag(divisor, is_signed);
                    prem_d    = '0;
                    zero_d    = (divisor == '0);
                    cnt_d     = '0;
                end
            end
            RUN: begin
                prem_d = borrow ? shifted : diff;
                dvd_d  = {dvd_q[WIDTH-2:0], ~borrow};
                cnt_d  = cnt_q + CW'(1);
            end
            FIX: begin
                // A zero divisor leaves r = |dividend|, so the normal remainder
                // sign fix restores the raw dividend; only the quotient is forced.
                quo_d  = zero_q ? '1 : (sgn_quo_q ? -dvd_q : dvd_q);
                rem_d  = sgn_rem_q ? -prem_q[WIDTH-1:0] : prem_q[WIDTH-1:0];
                div0_d = zero_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN) || (state_q == FIX);
        done = (state_q == DONE);
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign div0      = div0_q;
endmodule

// File: doc/mips_div_unit.md
Name: mips_div_unit

Overview:
- Multi-cycle 32-bit restoring divider for MIPS DIV/DIVU.
- Sits upstream of the 1-bit `sub` cell. Each iteration presents the partial remainder and divisor to a 33-bit ripple of `sub` cells, built from the team's existing full-subtractor.
- Consumes the borrow-out to decide restore vs. keep.
- Produces quotient (LO) and remainder (HI) for the HI/LO register stage, with a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk, input, 1, system clock; all state changes on its rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, request a division; sampled only in IDLE.
- is_signed, input, 1, 1 = DIV (two's complement), 0 = DIVU; sampled with start.
- dividend, input, WIDTH, numerator; sampled with start.
- divisor, input, WIDTH, denominator; sampled with start.
- busy, output, 1, high in RUN and FIX.
- done, output, 1, one-cycle pulse in DONE; results valid from this cycle.
- quotient, output, WIDTH, LO result; held until the next accepted start.
- remainder, output, WIDTH, HI result; held until the next accepted start.
- div0, output, 1, divisor was zero for the current result; held with results.

Behaviour:
- Reset (rst=1 at a rising edge), from any state including mid-RUN:
  - state goes to IDLE and the iteration counter goes to 0;
  - busy, done, div0, quotient and remainder all go to 0;
  - the operation in flight is discarded.
- States are IDLE, RUN, FIX and DONE.
- IDLE:
  - On an edge with start=1, latch the operands.
  - Record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend), both only when is_signed=1; otherwise both 0.
  - Load the working dividend register with |dividend| and the divisor register with |divisor|. For unsigned operation the operands load as-is. |0x80000000| = 0x80000000, interpreted unsigned.
  - Clear the partial remainder (WIDTH+1 bits).
  - Set div0 = (divisor == 0).
  - Set counter = 0 and go to RUN.
- RUN, one iteration per edge:
  - Shift {partial remainder, working dividend} left by 1.
  - Trial-subtract the divisor from the shifted partial remainder, WIDTH+1 bits, through the sub step.
  - If there is no borrow: keep the difference and shift in quotient bit 1. If there is a borrow: restore the shifted value and shift in 0.
  - Increment the counter. Leave RUN after exactly WIDTH iterations, i.e. on the edge where counter == WIDTH-1, going to FIX.
- FIX, one edge:
  - quotient = sign_q ? -q : q.
  - remainder = sign_r ? -r : r, using the low WIDTH bits of r.
  - Go to DONE.
- DONE, one cycle:
  - done=1, busy=0.
  - The next edge goes to IDLE.
- Latency: start sampled at edge E gives done=1 during the cycle after edge E+WIDTH+1, i.e. 33 cycles of busy for WIDTH=32.
- start while busy or in DONE is ignored: no restart, no queueing, and the operands are not resampled.
- start asserted in the same cycle as rst: reset wins.
- Divide by zero:
  - The unit runs with normal latency and no early exit.
  - quotient = all ones and remainder = original dividend (raw, no sign fix), div0=1.
  - This holds for both DIV and DIVU.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0, no flag.
- Remainder sign follows the dividend; quotient truncates toward zero (MIPS semantics).
- Outputs change only on the FIX edge and on reset. Between results they hold their last value.

Decomposition:
- Package mips_div_pkg:
  - state enum div_state_t {IDLE, RUN, FIX, DONE};
  - localparam DIV_WIDTH = 32;
  - counter width $clog2(DIV_WIDTH).
- Sub-module div_sub_step: a combinational (WIDTH+1)-bit subtractor built by chaining `sub` cells (cin = borrow chain, first cin = 0). Outputs the difference and the final borrow. Instantiated once in the divider.

Test Plan:
- DIVU, 100 / 7 -> after 33 busy cycles: done=1, quotient=14, remainder=2, div0=0.
- DIV, 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
- DIV, 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div0=0. Also DIVU 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0.
- DIVU, 5 / 0 -> quotient=0xFFFFFFFF, remainder=5, div0=1, done at normal latency. Then DIV 0xFFFFFFFB / 0 -> remainder=0xFFFFFFFB.
- Start 100/7, then pulse start with 9/3 at cycle 10 -> ignored; result is still 14/2 at the original done cycle.
- Start 100/7, assert rst at cycle 15 -> next cycle: IDLE, busy=0, all outputs 0, no done pulse. A new start of 9/3 then yields quotient=3, remainder=0.
